alu_operand_stage: RTL

Issue stage directly upstream of the execute ALU. Holds the architectural register file and a per-register pending scoreboard, accepts one instruction per cycle over a valid/ready handshake, and resolves both operands. It drives a registered operand/opcode bundle straight into the ALU's `i_elemA` / `i_elemB` / `i_op` inputs, and receives results back through a single writeback port.

---
 rtl/alu_operand_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the execute ALU: register file, per-register pending scoreboard, operand resolution.
// 1-cycle latency; o_in_ready drops on a source hazard or while a held bundle is not consumed.
package alu_operand_stage_pkg;
  typedef enum logic [2:0] {
    ADD_OP = 3'd0,
    SUB_OP = 3'd1,
    AND_OP = 3'd2,
    OR_OP  = 3'd3,
    XOR_OP = 3'd4,
    SLL_OP = 3'd5,
    SRL_OP = 3'd6,
    SRA_OP = 3'd7
  } alu_op_e;
endpackage

module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int REG_AW     = $clog2(NUM_REGS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  alu_op_e               i_op,
  input  logic [REG_AW-1:0]     i_rs1,
  input  logic [REG_AW-1:0]     i_rs2,
  input  logic [REG_AW-1:0]     i_rd,
  input  logic [DATA_WIDTH-1:0] i_imm,
  input  logic                  i_use_imm,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_elemA,
  output logic [DATA_WIDTH-1:0] o_elemB,
  output alu_op_e               o_op,
  output logic [REG_AW-1:0]     o_rd,
  input  logic                  i_wb_en,
  input  logic [REG_AW-1:0]     i_wb_rd,
  input  logic [DATA_WIDTH-1:0] i_wb_data
);

  logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
  logic [NUM_REGS-1:0]   pend_q, pend_d;

  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] elem_a_q, elem_a_d;
  logic [DATA_WIDTH-1:0] elem_b_q, elem_b_d;
  alu_op_e               op_q, op_d;
  logic [REG_AW-1:0]     rd_q, rd_d;

  logic                  wb_hit_rs1, wb_hit_rs2;
  logic                  haz_rs1, haz_rs2, hazard, accept;
  logic [DATA_WIDTH-1:0] opnd_a, opnd_b;

  // A writeback in flight this cycle both resolves the hazard and supplies the data.
  assign wb_hit_rs1 = i_wb_en && (i_wb_rd == i_rs1) && (i_rs1 != '0);
  assign wb_hit_rs2 = i_wb_en && (i_wb_rd == i_rs2) && (i_rs2 != '0);

  assign haz_rs1 = pend_q[i_rs1] && !wb_hit_rs1;
  assign haz_rs2 = !i_use_imm && pend_q[i_rs2] && !wb_hit_rs2;
  assign hazard  = haz_rs1 || haz_rs2;

  assign o_in_ready = (!out_vld_q || i_out_ready) && !hazard;
  assign accept     = i_in_valid && o_in_ready;

  assign opnd_a = wb_hit_rs1 ? i_wb_data : rf_q[i_rs1];
  assign opnd_b = i_use_imm  ? i_imm
                : wb_hit_rs2 ? i_wb_data
                : rf_q[i_rs2];

  always_comb begin
    pend_d    = pend_q;
    out_vld_d = out_vld_q;
    elem_a_d  = elem_a_q;
    elem_b_d  = elem_b_q;
    op_d      = op_q;
    rd_d      = rd_q;

    if (i_wb_en) begin
      pend_d[i_wb_rd] = 1'b0;
    end
    // Applied after the clear so a same-cycle issue to the same register keeps it pending.
    if (accept && (i_rd != '0)) begin
      pend_d[i_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;

    if (accept) begin
      out_vld_d = 1'b1;
      elem_a_d  = opnd_a;
      elem_b_d  = opnd_b;
      op_d      = i_op;
      rd_d      = i_rd;
    end else if (i_out_ready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (i_wb_en && (i_wb_rd != '0)) begin
      rf_q[i_wb_rd] <= i_wb_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q    <= '0;
      out_vld_q <= 1'b0;
      elem_a_q  <= '0;
      elem_b_q  <= '0;
      op_q      <= ADD_OP;
      rd_q      <= '0;
    end else begin
      pend_q    <= pend_d;
      out_vld_q <= out_vld_d;
      elem_a_q  <= elem_a_d;
      elem_b_q  <= elem_b_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
    end
  end

  assign o_out_valid = out_vld_q;
  assign o_elemA     = elem_a_q;
  assign o_elemB     = elem_b_q;
  assign o_op        = op_q;
  assign o_rd        = rd_q;

endmodule
